// File: rtl/button_reboot_ctrl.sv
// Debounces the user button into short/long press events; a long hold can pulse RST_N low
// to reboot the FPGA. Drives the active-low RGB LED with press/hold/reboot feedback.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | button released, waiting for a press
// DB_PRESS | press seen, waiting for DEBOUNCE_CYCLES stable cycles
// HELD     | press accepted, hold_cnt timing toward a long hold
// DB_REL   | release seen while held, debouncing it (hold_cnt frozen)
// REBOOT   | RST_N driven low for RST_PULSE_CYCLES
// WAIT_REL | long hold handled, waiting for a debounced release
module button_reboot_ctrl #(
   parameter int DEBOUNCE_CYCLES  = 480000,
   parameter int LONG_CYCLES      = 96000000,
   parameter int RST_PULSE_CYCLES = 48
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_N,
   input  logic       REBOOT_EN,
   output logic       SHORT_PRESS,
   output logic       LONG_PRESS,
   output logic       RST_N,
   output logic [2:0] LED_N
);

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > RST_PULSE_CYCLES) ? DEBOUNCE_CYCLES
                                                                 : RST_PULSE_CYCLES;
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST  = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] LONG_HALF  = HW'(LONG_CYCLES / 2);

   localparam logic [2:0] LED_OFF   = 3'b111;
   localparam logic [2:0] LED_BLUE  = 3'b110;
   localparam logic [2:0] LED_GREEN = 3'b101;
   localparam logic [2:0] LED_RED   = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DB_PRESS = 3'd1,
      S_HELD     = 3'd2,
      S_DB_REL   = 3'd3,
      S_REBOOT   = 3'd4,
      S_WAIT_REL = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          rebooted, rebooted_nxt;
   logic          sync_1, sync_2;
   logic          pressed;
   logic          short_nxt, long_nxt, rst_n_nxt;
   logic [2:0]    led_nxt;

   // BTN_N is asynchronous to CLK; the FSM only ever looks at sync_2.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= BTN_N;
         sync_2 <= sync_1;
      end
   end

   assign pressed = ~sync_2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         cnt         <= '0;
         hold_cnt    <= '0;
         rebooted    <= 1'b0;
         SHORT_PRESS <= 1'b0;
         LONG_PRESS  <= 1'b0;
         RST_N       <= 1'b1;
         LED_N       <= LED_OFF;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         hold_cnt    <= hold_nxt;
         rebooted    <= rebooted_nxt;
         SHORT_PRESS <= short_nxt;
         LONG_PRESS  <= long_nxt;
         RST_N       <= rst_n_nxt;
         LED_N       <= led_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      hold_nxt     = hold_cnt;
      rebooted_nxt = rebooted;
      short_nxt    = 1'b0;
      long_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (pressed) begin
               state_nxt = S_DB_PRESS;
               cnt_nxt   = '0;
            end
         end
         S_DB_PRESS: begin
            if (!pressed) begin
               state_nxt = S_IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_HELD;
               hold_nxt  = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_HELD: begin
            if (!pressed) begin
               state_nxt = S_DB_REL;
               cnt_nxt   = '0;
            end else if (hold_cnt == LONG_LAST) begin
               // REBOOT_EN matters only on this decision cycle.
               cnt_nxt      = '0;
               rebooted_nxt = REBOOT_EN;
               if (REBOOT_EN) begin
                  state_nxt = S_REBOOT;
               end else begin
                  long_nxt  = 1'b1;
                  state_nxt = S_WAIT_REL;
               end
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         S_DB_REL: begin
            if (pressed) begin
               state_nxt = S_HELD;
            end else if (cnt == DB_LAST) begin
               short_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_REBOOT: begin
            if (cnt == PULSE_LAST) begin
               state_nxt = S_WAIT_REL;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_WAIT_REL: begin
            if (pressed) begin
               cnt_nxt = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      rst_n_nxt = (state != S_REBOOT);
      led_nxt   = LED_OFF;
      case (state)
         S_DB_PRESS, S_DB_REL: led_nxt = LED_BLUE;
         S_HELD:               led_nxt = (hold_cnt >= LONG_HALF) ? LED_GREEN : LED_BLUE;
         S_REBOOT:             led_nxt = LED_RED;
         S_WAIT_REL:           led_nxt = rebooted ? LED_RED : LED_GREEN;
         default:              led_nxt = LED_OFF;
      endcase
   end

endmodule

// File: tb/tb_button_reboot_ctrl.sv
// Scoreboard bench for button_reboot_ctrl: the driver runs a run-length reference model per
// cycle and queues expected LED values and events; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_button_reboot_ctrl;

   localparam int DB = 4;
   localparam int LC = 20;
   localparam int RP = 3;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BTN_N;
   logic       REBOOT_EN;
   logic       SHORT_PRESS;
   logic       LONG_PRESS;
   logic       RST_N;
   logic [2:0] LED_N;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int edge_no;
      int kind;      // 0 short press, 1 long press, 2 RST_N low
   } ev_t;

   ev_t        ev_q[$];
   logic [2:0] led_q[$];
   bit         mon_on   = 1'b0;
   int         mon_edge = 0;

   // Reference model: phases of a press described by run lengths of the synchronized button.
   localparam int M_IDLE = 0, M_ARM = 1, M_HOLD = 2, M_REL = 3, M_BOOT = 4, M_DRAIN = 5;
   int m_mode, m_press_run, m_rel_run, m_held, m_since, m_edge;
   bit m_h1, m_h2, m_rebooted;

   button_reboot_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LC),
      .RST_PULSE_CYCLES(RP)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN_N      (BTN_N),
      .REBOOT_EN  (REBOOT_EN),
      .SHORT_PRESS(SHORT_PRESS),
      .LONG_PRESS (LONG_PRESS),
      .RST_N      (RST_N),
      .LED_N      (LED_N)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, mon_edge, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode      = M_IDLE;
      m_press_run = 0;
      m_rel_run   = 0;
      m_held      = 0;
      m_since     = 0;
      m_edge      = 0;
      m_h1        = 1'b1;
      m_h2        = 1'b1;
      m_rebooted  = 1'b0;
      mon_edge    = 0;
   endtask

   task automatic enter(input int mode);
      m_mode  = mode;
      m_since = 0;
   endtask

   task automatic push_ev(input int kind);
      ev_t e;
      e.edge_no = m_edge;
      e.kind    = kind;
      ev_q.push_back(e);
   endtask

   // Expectations for the clock edge that follows the inputs just driven.
   task automatic model_step(input bit b, input bit en);
      bit pressed;
      pressed = (m_h2 == 1'b0);
      m_h2 = m_h1;
      m_h1 = b;

      case (m_mode)
         M_ARM, M_REL: led_q.push_back(3'b110);
         M_HOLD:       led_q.push_back((m_held >= LC / 2) ? 3'b101 : 3'b110);
         M_BOOT:       led_q.push_back(3'b011);
         M_DRAIN:      led_q.push_back(m_rebooted ? 3'b011 : 3'b101);
         default:      led_q.push_back(3'b111);
      endcase
      if (m_mode == M_BOOT) push_ev(2);

      m_press_run = pressed ? m_press_run + 1 : 0;
      m_rel_run   = pressed ? 0 : m_rel_run + 1;
      m_since++;

      case (m_mode)
         M_IDLE: if (pressed) enter(M_ARM);
         M_ARM: begin
            if (!pressed) enter(M_IDLE);
            else if (m_press_run == DB + 1) begin
               m_held = 0;
               enter(M_HOLD);
            end
         end
         M_HOLD: begin
            if (!pressed) enter(M_REL);
            else begin
               m_held++;
               if (m_held == LC) begin
                  m_rebooted = en;
                  if (en) enter(M_BOOT);
                  else begin
                     push_ev(1);
                     enter(M_DRAIN);
                  end
               end
            end
         end
         M_REL: begin
            if (pressed) enter(M_HOLD);
            else if (m_rel_run == DB + 1) begin
               push_ev(0);
               enter(M_IDLE);
            end
         end
         M_BOOT: if (m_since == RP) enter(M_DRAIN);
         default: if (m_rel_run >= DB && m_since >= DB) enter(M_IDLE);
      endcase
      m_edge++;
   endtask

   // en_mode: 0 or 1 holds REBOOT_EN fixed, 2 randomizes it every cycle.
   task automatic drive(input bit b, input int n, input int en_mode);
      for (int i = 0; i < n; i++) begin
         BTN_N     = b;
         REBOOT_EN = (en_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(en_mode);
         model_step(b, REBOOT_EN);
         @(negedge CLK);
      end
   endtask

   task automatic mon_event(input int kind);
      ev_t e;
      if (ev_q.size() == 0) begin
         check("unexpected_event_kind", kind, -1);
      end else begin
         e = ev_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_edge", mon_edge, e.edge_no);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (mon_on) begin
            while (ev_q.size() > 0 && ev_q[0].edge_no < mon_edge) begin
               check("missed_event_kind", -1, ev_q[0].kind);
               void'(ev_q.pop_front());
            end
            if (led_q.size() == 0) check("led_queue_underflow", 0, 1);
            else check("led_n", int'(LED_N), int'(led_q.pop_front()));
            if (SHORT_PRESS) mon_event(0);
            if (LONG_PRESS)  mon_event(1);
            if (!RST_N)      mon_event(2);
            mon_edge++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  en;
      bit  got;
      RST       = 1'b1;
      BTN_N     = 1'b1;
      REBOOT_EN = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_rst_n", int'(RST_N), 1);
      check("reset_led_n", int'(LED_N), 7);
      check("reset_short", int'(SHORT_PRESS), 0);
      check("reset_long",  int'(LONG_PRESS), 0);

      RST = 1'b0;
      model_reset();
      mon_on = 1'b1;

      drive(1, 5, 0);
      drive(0, 3, 0);  drive(1, 10, 0);
      drive(0, 10, 0); drive(1, 12, 0);
      drive(0, 8, 0);  drive(1, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
      drive(0, 6, 0);  drive(1, 12, 0);
      drive(0, 16, 0); drive(1, 1, 0); drive(0, 12, 0); drive(1, 12, 0);
      drive(0, 40, 1); drive(1, 12, 1);
      drive(0, 40, 0); drive(1, 12, 0);

      repeat (60) begin
         en = $urandom_range(0, 2);
         drive(0, $urandom_range(1, 34), en);
         if ($urandom_range(0, 2) == 0) begin
            drive(1, 1, en);
            drive(0, $urandom_range(1, 12), en);
         end
         drive(1, $urandom_range(1, 14), en);
      end
      drive(1, 15, 0);
      mon_on = 1'b0;
      check("events_drained_a", ev_q.size(), 0);
      check("leds_drained_a", led_q.size(), 0);

      BTN_N     = 1'b0;
      REBOOT_EN = 1'b1;
      got       = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(posedge CLK);
         #1;
         if (!RST_N) got = 1'b1;
      end
      check("reboot_reached", int'(got), 1);
      @(posedge CLK);
      #1;
      check("rst_n_second_low", int'(RST_N), 0);
      RST = 1'b1;
      #1;
      check("midboot_rst_n", int'(RST_N), 1);
      check("midboot_led_n", int'(LED_N), 7);
      check("midboot_short", int'(SHORT_PRESS), 0);
      check("midboot_long",  int'(LONG_PRESS), 0);

      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      mon_on = 1'b1;
      drive(0, 40, 0);
      drive(1, 15, 0);
      mon_on = 1'b0;
      check("events_drained_b", ev_q.size(), 0);
      check("leds_drained_b", led_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
